// File: rtl/vga_sync_to_count_pkg.sv
// Shared VGA timing definitions: default 640x480 constants, count width and the
// lock-state encoding used by the sync-to-count receiver.
package vga_sync_to_count_pkg;

    localparam int COUNT_W         = 10;
    localparam int VGA_TOTAL_COLS  = 800;
    localparam int VGA_TOTAL_ROWS  = 525;
    localparam int VGA_ACTIVE_COLS = 640;
    localparam int VGA_ACTIVE_ROWS = 480;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    // Saturating 8-bit increment used by the optional error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'hFF) begin
            res = val;
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_sync_to_count_sync_edge_detect.sv
// One-cycle registered copy of a sync flag plus a rising-edge pulse. The edge
// history resets high so a level already asserted at reset release is not an edge.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic sync_o,
    output logic edge_o
);

    logic hist_q;
    logic sync_q;

    // History and output delay registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= 1'b1;
            sync_q <= 1'b0;
        end else begin
            hist_q <= sync_i;
            sync_q <= sync_i;
        end
    end

    assign edge_o = sync_i & ~hist_q;
    assign sync_o = sync_q;

endmodule

// File: rtl/vga_sync_to_count.sv
// Rebuilds column/row counts from active-region HSync/VSync flags, with lock FSM and
// timing-error detection. Optional error counter: VGA_SYNC_TO_COUNT_ERR_CNT_EN.
module vga_sync_to_count
    import vga_sync_to_count_pkg::*;
#(
    parameter int TOTAL_COLS  = VGA_TOTAL_COLS,
    parameter int TOTAL_ROWS  = VGA_TOTAL_ROWS,
    parameter int ACTIVE_COLS = VGA_ACTIVE_COLS,
    parameter int ACTIVE_ROWS = VGA_ACTIVE_ROWS
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_HSync,
    input  logic               i_VSync,
    output logic               o_HSync,
    output logic               o_VSync,
    output logic [COUNT_W-1:0] o_Col_Count,
    output logic [COUNT_W-1:0] o_Row_Count,
    output logic               o_Frame_Start,
    output logic               o_Locked,
`ifdef VGA_SYNC_TO_COUNT_ERR_CNT_EN
    output logic [7:0]         o_Err_Count,
`endif
    output logic               o_Sync_Err
);

    localparam logic [COUNT_W-1:0] COL_LAST = COUNT_W'(TOTAL_COLS - 1);
    localparam logic [COUNT_W-1:0] ROW_LAST = COUNT_W'(TOTAL_ROWS - 1);
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);

    if (ACTIVE_COLS >= TOTAL_COLS || ACTIVE_ROWS >= TOTAL_ROWS) begin : g_bad_cfg
        $error("vga_sync_to_count: active region must be smaller than total timing");
    end

    logic h_edge_s;
    logic f_edge_s;
    logic line_err_s;
    logic frame_err_s;

    logic [COUNT_W-1:0] col_q, col_d;
    logic [COUNT_W-1:0] row_q, row_d;
    lock_state_e        state_q, state_d;
    logic               armed_q, armed_d;
    logic               err_d;
    logic               frame_start_q;
    logic               sync_err_q;
    logic               locked_q;

    sync_edge_detect u_h_edge (
        .clk_i  (i_Clk),
        .rst_i  (i_Reset),
        .sync_i (i_HSync),
        .sync_o (o_HSync),
        .edge_o (h_edge_s)
    );

    sync_edge_detect u_v_edge (
        .clk_i  (i_Clk),
        .rst_i  (i_Reset),
        .sync_i (i_VSync),
        .sync_o (o_VSync),
        .edge_o (f_edge_s)
    );

    // Free-running counters, forced to the origin on a frame start
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (f_edge_s) begin
            col_d = '0;
            row_d = '0;
        end else if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
                row_d = '0;
            end else begin
                row_d = row_q + CNT_ONE;
            end
        end else begin
            col_d = col_q + CNT_ONE;
        end
    end

    // A frame-start H-edge is covered by the frame check, not the line check
    always_comb begin
        line_err_s  = h_edge_s && !f_edge_s && (col_q != COL_LAST);
        frame_err_s = f_edge_s && !(h_edge_s && (col_q == COL_LAST) && (row_q == ROW_LAST));
    end

    // Lock FSM: armed_q means the current CHECK window began at a frame start with no line error since
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        err_d   = 1'b0;
        case (state_q)
            SEARCH: begin
                if (f_edge_s) begin
                    state_d = CHECK;
                    armed_d = 1'b1;
                end else begin
                    state_d = SEARCH;
                end
            end
            CHECK: begin
                if (line_err_s) begin
                    err_d   = 1'b1;
                    armed_d = 1'b0;
                end else if (frame_err_s) begin
                    err_d   = 1'b1;
                    armed_d = 1'b1;
                end else if (f_edge_s) begin
                    if (armed_q) begin
                        state_d = LOCKED;
                    end else begin
                        armed_d = 1'b1;
                    end
                end else begin
                    state_d = CHECK;
                end
            end
            LOCKED: begin
                if (line_err_s || frame_err_s) begin
                    err_d   = 1'b1;
                    state_d = SEARCH;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = SEARCH;
                armed_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            col_q         <= '0;
            row_q         <= '0;
            state_q       <= SEARCH;
            armed_q       <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            state_q       <= state_d;
            armed_q       <= armed_d;
            frame_start_q <= f_edge_s;
            sync_err_q    <= err_d;
            locked_q      <= (state_d == LOCKED);
        end
    end

`ifdef VGA_SYNC_TO_COUNT_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of reported timing errors
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            err_cnt_q <= 8'd0;
        end else if (err_d) begin
            err_cnt_q <= sat_inc8(err_cnt_q);
        end else begin
            err_cnt_q <= err_cnt_q;
        end
    end

    assign o_Err_Count = err_cnt_q;
`endif

    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Frame_Start = frame_start_q;
    assign o_Sync_Err    = sync_err_q;
    assign o_Locked      = locked_q;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Directed bench for vga_sync_to_count on a 10x6 timing (8x4 active) driven by a
// small generator model; error-counter steps build only with VGA_SYNC_TO_COUNT_ERR_CNT_EN.
module tb_vga_sync_to_count;

    localparam int TC = 10;
    localparam int TR = 6;
    localparam int AC = 8;
    localparam int AR = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs;
    logic       vs;
    logic       o_hs;
    logic       o_vs;
    logic       o_fs;
    logic       o_lk;
    logic       o_er;
    logic [9:0] o_col;
    logic [9:0] o_row;
`ifdef VGA_SYNC_TO_COUNT_ERR_CNT_EN
    logic [7:0] o_ecnt;
`endif

    int errors = 0;
    int checks = 0;
    int gcol;
    int grow;
    int fs_cnt;
    int lock_at;
    bit aligned;
    bit err_exp;

    always #20 clk = ~clk;

    vga_sync_to_count #(
        .TOTAL_COLS  (TC),
        .TOTAL_ROWS  (TR),
        .ACTIVE_COLS (AC),
        .ACTIVE_ROWS (AR)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_HSync       (hs),
        .i_VSync       (vs),
        .o_HSync       (o_hs),
        .o_VSync       (o_vs),
        .o_Col_Count   (o_col),
        .o_Row_Count   (o_row),
        .o_Frame_Start (o_fs),
        .o_Locked      (o_lk),
`ifdef VGA_SYNC_TO_COUNT_ERR_CNT_EN
        .o_Err_Count   (o_ecnt),
`endif
        .o_Sync_Err    (o_er)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b (gen col=%0d row=%0d)", tag, obs, exp, gcol, grow);
        end
    endtask

    task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (gen col=%0d row=%0d)", tag, obs, exp, gcol, grow);
        end
    endtask

    task automatic chk_reset_outputs();
        chk1("rst_hsync", o_hs, 1'b0);
        chk1("rst_vsync", o_vs, 1'b0);
        chk10("rst_col", o_col, 10'd0);
        chk10("rst_row", o_row, 10'd0);
        chk1("rst_frame_start", o_fs, 1'b0);
        chk1("rst_locked", o_lk, 1'b0);
        chk1("rst_sync_err", o_er, 1'b0);
    endtask

    task automatic gen_adv();
        if (gcol == TC - 1) begin
            gcol = 0;
            grow = (grow == TR - 1) ? 0 : grow + 1;
        end else begin
            gcol = gcol + 1;
        end
    endtask

    // One generator cycle; hold forces both flags low while the position model keeps running
    task automatic gen_step(input bit hold);
        bit fs_now;
        fs_now = !hold && (gcol == 0) && (grow == 0);
        if (fs_now) begin
            fs_cnt++;
            aligned = 1'b1;
        end
        hs = hold ? 1'b0 : (gcol < AC);
        vs = hold ? 1'b0 : (grow < AR);
        @(posedge clk);
        #1;
        chk1("hsync", o_hs, hs);
        chk1("vsync", o_vs, vs);
        chk1("frame_start", o_fs, fs_now);
        chk1("locked", o_lk, fs_cnt >= lock_at);
        chk1("sync_err", o_er, err_exp);
        if (aligned) begin
            chk10("col", o_col, 10'(gcol));
            chk10("row", o_row, 10'(grow));
        end
        err_exp = 1'b0;
        gen_adv();
    endtask

    initial begin
        rst     = 1'b1;
        hs      = 1'b0;
        vs      = 1'b0;
        aligned = 1'b0;
        err_exp = 1'b0;
        fs_cnt  = 0;
        lock_at = 2;
        gcol    = 0;
        grow    = 4;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;

        // Clean stream from vertical blanking: 20 lead-in cycles then 3 full frames
        repeat (200) gen_step(1'b0);

        // Shorten line 1 of the next frame to 9 cycles by skipping blanking column 8
        repeat (18) gen_step(1'b0);
        aligned = 1'b0;
        gcol    = 9;
        gen_step(1'b0);
        lock_at = fs_cnt + 2;
        err_exp = 1'b1;
        gen_step(1'b0);
        repeat (129) gen_step(1'b0);

        // One-cycle reset while locked mid-line, released with both flags high
        repeat (3) gen_step(1'b0);
        rst = 1'b1;
        hs  = (gcol < AC);
        vs  = (grow < AR);
        @(posedge clk);
        #1;
        chk_reset_outputs();
        rst     = 1'b0;
        gen_adv();
        aligned = 1'b0;
        lock_at = fs_cnt + 2;
        repeat (96) gen_step(1'b0);

        // Inputs held low: counters keep running, lock is kept
        repeat (12) gen_step(1'b1);

`ifdef VGA_SYNC_TO_COUNT_ERR_CNT_EN
        chk10("err_cnt_clear", {2'b00, o_ecnt}, 10'd0);
        hs = 1'b0;
        vs = 1'b1;
        @(posedge clk);
        #1;
        vs = 1'b0;
        @(posedge clk);
        #1;
        vs = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            hs = 1'b1;
            @(posedge clk);
            #1;
            hs = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        chk10("err_cnt_sat", {2'b00, o_ecnt}, 10'd255);
        chk1("err_cnt_locked", o_lk, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
